// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, RAM handshake state, arbiter states.
// DBLK_W sets the dcache block size used as the arbiter default.
package cpu_types_pkg;

  parameter int DBLK_W = 1;
  parameter int DBLK_WORDS = 2**DBLK_W;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IXFER,
    ARB_DXFER,
    ARB_DDONE
  } arbstate_t;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the unified RAM port between icache word fetches and
// dcache block transfers, with a one-bit fairness flag for icache.
module ram_arbiter
  import cpu_types_pkg::*;
#(
  parameter int BLK_WORDS = DBLK_WORDS
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   iREN,
  input  word_t                  iaddr,
  output logic                   iwait,
  output word_t                  iload,
  input  logic                   dREN,
  input  logic                   dWEN,
  input  word_t                  daddr,
  input  logic [32*BLK_WORDS-1:0] dstore,
  output logic                   dwait,
  output logic [32*BLK_WORDS-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output word_t                  ramaddr,
  output word_t                  ramstore,
  input  word_t                  ramload,
  input  ramstate_t              ramstate,
  output logic                   memerr
);

  localparam int CW = $clog2(BLK_WORDS);

  arbstate_t     state, nxt;
  logic [CW-1:0] wcnt;
  logic          ifirst;
  logic          dwrite;
  logic          dreq;
  logic          last;
  logic          unused_low;

  assign dreq = dREN | dWEN;
  assign last = (wcnt == CW'(BLK_WORDS - 1));
  assign unused_low = ^daddr[CW+1:0];

  always_comb begin
    nxt      = state;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      ARB_IDLE: begin
        if (ifirst && iREN) nxt = ARB_IXFER;
        else if (dreq)      nxt = ARB_DXFER;
        else if (iREN)      nxt = ARB_IXFER;
      end
      ARB_IXFER: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (!iREN) begin
          nxt = ARB_IDLE;
        end else if (ramstate == ACCESS) begin
          iwait = 1'b0;
          iload = ramload;
          nxt   = ARB_IDLE;
        end
      end
      ARB_DXFER: begin
        // direction comes from the latched grant, never live inputs
        ramREN  = !dwrite;
        ramWEN  = dwrite;
        ramaddr = {daddr[31:CW+2], wcnt, 2'b00};
        if (dwrite) ramstore = dstore[32*wcnt +: 32];
        if (!dreq)                             nxt = ARB_IDLE;
        else if (ramstate == ACCESS && last)   nxt = ARB_DDONE;
      end
      ARB_DDONE: begin
        dwait = 1'b0;
        nxt   = ARB_IDLE;
      end
      default: nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ARB_IDLE;
      wcnt   <= '0;
      ifirst <= 1'b0;
      dwrite <= 1'b0;
      dload  <= '0;
      memerr <= 1'b0;
    end else begin
      state <= nxt;
      if ((state == ARB_IXFER || state == ARB_DXFER)
          && ramstate == ERROR)
        memerr <= 1'b1;
      unique case (state)
        ARB_IDLE: begin
          wcnt   <= '0;
          dwrite <= dWEN;
        end
        ARB_IXFER: begin
          if (iREN && ramstate == ACCESS) ifirst <= 1'b0;
        end
        ARB_DXFER: begin
          if (dreq && ramstate == ACCESS) begin
            if (!dwrite) dload[32*wcnt +: 32] <= ramload;
            wcnt <= wcnt + 1'b1;
          end
        end
        ARB_DDONE: ifirst <= iREN;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: vector table, directed
// corner sequences and random traffic against a transaction model.
module tb_ram_arbiter;
  import cpu_types_pkg::*;

  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          RST;
  logic          iREN, dREN, dWEN;
  word_t         iaddr, daddr, ramload;
  logic [32*BW-1:0] dstore;
  ramstate_t     rs;
  logic          iwait, dwait, ramREN, ramWEN, memerr;
  word_t         iload, ramaddr, ramstore;
  logic [32*BW-1:0] dload;

  int n_chk = 0;
  int n_fail = 0;

  // model: 0 idle, 1 icache word, 2 dcache block, 3 block done
  int         m_st, m_k;
  bit         m_first, m_wr, m_err;
  logic [31:0] m_dl [BW];

  ram_arbiter #(.BLK_WORDS(BW)) dut (
    .CLK(clk), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(rs),
    .memerr(memerr)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_k = 0; m_first = 0; m_wr = 0; m_err = 0;
    for (int i = 0; i < BW; i++) m_dl[i] = '0;
  endtask

  task automatic settle();
    logic e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_st, e_il;
    logic [63:0] e_dl;
    #1;
    e_ren = 0; e_wen = 0; e_iw = 1; e_dw = 1;
    e_addr = 0; e_st = 0; e_il = 0;
    for (int i = 0; i < BW; i++) e_dl[32*i +: 32] = m_dl[i];
    if (m_st == 1) begin
      e_ren = 1; e_addr = iaddr;
      if (iREN && rs == ACCESS) begin e_iw = 0; e_il = ramload; end
    end else if (m_st == 2) begin
      e_addr = (daddr & ~32'(BW * 4 - 1)) + 32'(4 * m_k);
      if (m_wr) begin e_wen = 1; e_st = dstore[32*m_k +: 32]; end
      else e_ren = 1;
    end else if (m_st == 3) begin
      e_dw = 0;
    end
    chk("ramREN", 64'(ramREN), 64'(e_ren));
    chk("ramWEN", 64'(ramWEN), 64'(e_wen));
    chk("ramaddr", 64'(ramaddr), 64'(e_addr));
    chk("ramstore", 64'(ramstore), 64'(e_st));
    chk("iwait", 64'(iwait), 64'(e_iw));
    chk("iload", 64'(iload), 64'(e_il));
    chk("dwait", 64'(dwait), 64'(e_dw));
    chk("dload", 64'(dload), e_dl);
    chk("memerr", 64'(memerr), 64'(m_err));
  endtask

  task automatic adv();
    bit dq;
    dq = dREN | dWEN;
    if (RST) model_reset();
    else begin
      if ((m_st == 1 || m_st == 2) && rs == ERROR) m_err = 1;
      case (m_st)
        0: if (m_first && iREN) m_st = 1;
           else if (dq) begin m_st = 2; m_k = 0; m_wr = dWEN; end
           else if (iREN) m_st = 1;
        1: if (!iREN) m_st = 0;
           else if (rs == ACCESS) begin m_first = 0; m_st = 0; end
        2: if (!dq) m_st = 0;
           else if (rs == ACCESS) begin
             if (!m_wr) m_dl[m_k] = ramload;
             if (m_k == BW - 1) m_st = 3; else m_k++;
           end
        default: begin m_first = iREN; m_st = 0; end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle_in();
    iREN = 0; dREN = 0; dWEN = 0; rs = FREE;
    iaddr = 0; daddr = 0; dstore = '0; ramload = 0;
  endtask

  typedef struct {
    logic iren; logic [31:0] ia;
    logic dren; logic [31:0] da;
    ramstate_t r; logic [31:0] rl;
    logic e_ren; logic [31:0] e_addr;
    logic e_iw; logic [31:0] e_il;
    logic e_dw; logic [63:0] e_dl;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic dr,
      logic [31:0] da, ramstate_t r, logic [31:0] rl, logic er,
      logic [31:0] ea, logic ew, logic [31:0] el, logic dw,
      logic [63:0] dl);
    vec_t v;
    v.iren = ir; v.ia = ia; v.dren = dr; v.da = da; v.r = r;
    v.rl = rl; v.e_ren = er; v.e_addr = ea; v.e_iw = ew;
    v.e_il = el; v.e_dw = dw; v.e_dl = dl;
    return v;
  endfunction

  initial begin
    idle_in();
    RST = 1;
    @(negedge clk);
    model_reset();
    settle();
    chk("rst_memerr", 64'(memerr), 64'd0);
    chk("rst_iwait", 64'(iwait), 64'd1);
    adv();
    RST = 0;

    // single fetch, then block fill with 2 BUSY cycles per word
    vt.push_back(mk(1,'h40,0,0,ACCESS,'hDEADBEEF, 0,0,1,0,1,0));
    vt.push_back(mk(1,'h40,0,0,ACCESS,'hDEADBEEF,
                    1,'h40,0,'hDEADBEEF,1,0));
    vt.push_back(mk(0,'h40,0,0,FREE,0, 0,0,1,0,1,0));
    vt.push_back(mk(0,0,1,'h104,BUSY,0, 0,0,1,0,1,0));
    vt.push_back(mk(0,0,1,'h104,BUSY,0, 1,'h100,1,0,1,0));
    vt.push_back(mk(0,0,1,'h104,BUSY,0, 1,'h100,1,0,1,0));
    vt.push_back(mk(0,0,1,'h104,ACCESS,'h11, 1,'h100,1,0,1,0));
    vt.push_back(mk(0,0,1,'h104,BUSY,0, 1,'h104,1,0,1,'h11));
    vt.push_back(mk(0,0,1,'h104,BUSY,0, 1,'h104,1,0,1,'h11));
    vt.push_back(mk(0,0,1,'h104,ACCESS,'h22, 1,'h104,1,0,1,'h11));
    vt.push_back(mk(0,0,1,'h104,FREE,0, 0,0,1,0,0,
                    64'h00000022_00000011));
    vt.push_back(mk(0,0,0,'h104,FREE,0, 0,0,1,0,1,
                    64'h00000022_00000011));
    foreach (vt[i]) begin
      iREN = vt[i].iren; iaddr = vt[i].ia;
      dREN = vt[i].dren; daddr = vt[i].da;
      rs = vt[i].r; ramload = vt[i].rl;
      settle();
      chk($sformatf("v%0d_ren", i), 64'(ramREN), 64'(vt[i].e_ren));
      chk($sformatf("v%0d_addr", i), 64'(ramaddr), 64'(vt[i].e_addr));
      chk($sformatf("v%0d_iwait", i), 64'(iwait), 64'(vt[i].e_iw));
      chk($sformatf("v%0d_iload", i), 64'(iload), 64'(vt[i].e_il));
      chk($sformatf("v%0d_dwait", i), 64'(dwait), 64'(vt[i].e_dw));
      chk($sformatf("v%0d_dload", i), 64'(dload), vt[i].e_dl);
      adv();
    end

    // contention: d block, one fetch, d block again
    idle_in();
    iREN = 1; dWEN = 1; iaddr = 'h80; daddr = 'h500;
    dstore = {32'hCAFE0001, 32'hCAFE0000}; rs = ACCESS;
    for (int c = 0; c < 8; c++) begin
      logic [7:0] wen_e, ren_e;
      wen_e = 8'b1000_0110;
      ren_e = 8'b0010_0000;
      settle();
      chk($sformatf("ct%0d_wen", c), 64'(ramWEN), 64'(wen_e[c]));
      chk($sformatf("ct%0d_ren", c), 64'(ramREN), 64'(ren_e[c]));
      if (c == 1) chk("ct_store0", 64'(ramstore), 64'hCAFE0000);
      if (c == 2) chk("ct_store1", 64'(ramstore), 64'hCAFE0001);
      if (c == 5) chk("ct_iwait", 64'(iwait), 64'd0);
      adv();
    end
    idle_in();
    for (int c = 0; c < 2; c++) begin settle(); adv(); end

    // ERROR on first word, retried at the same address
    dREN = 1; daddr = 'h200;
    for (int c = 0; c < 6; c++) begin
      rs = (c == 1) ? ERROR : ACCESS;
      if (c == 5) dREN = 0;
      settle();
      if (c == 1 || c == 2) chk("er_addr", 64'(ramaddr), 64'h200);
      if (c >= 2) chk("er_memerr", 64'(memerr), 64'd1);
      if (c == 4) chk("er_dwait", 64'(dwait), 64'd0);
      adv();
    end

    // reset during word 1, then request restarts at word 0
    dREN = 1; daddr = 'h300;
    for (int c = 0; c < 8; c++) begin
      RST = (c == 2);
      rs = (c == 2) ? BUSY : ACCESS;
      if (c == 7) dREN = 0;
      settle();
      if (c == 2) chk("rm_addr1", 64'(ramaddr), 64'h304);
      if (c == 3) begin
        chk("rm_ren", 64'(ramREN | ramWEN), 64'd0);
        chk("rm_dwait", 64'(dwait), 64'd1);
        chk("rm_memerr", 64'(memerr), 64'd0);
      end
      if (c == 4) chk("rm_restart", 64'(ramaddr), 64'h300);
      if (c == 6) chk("rm_done", 64'(dwait), 64'd0);
      adv();
    end
    RST = 0;

    // drop during word 0; waiting icache granted after one idle
    iREN = 1; iaddr = 'h44; dREN = 1; daddr = 'h600;
    for (int c = 0; c < 6; c++) begin
      rs = (c >= 3) ? ACCESS : BUSY;
      if (c == 2) dREN = 0;
      if (c == 5) iREN = 0;
      settle();
      chk($sformatf("dr%0d_dwait", c), 64'(dwait), 64'd1);
      if (c == 3) chk("dr_idle", 64'(ramREN), 64'd0);
      if (c == 4) begin
        chk("dr_iren", 64'(ramREN), 64'd1);
        chk("dr_iaddr", 64'(ramaddr), 64'h44);
      end
      adv();
    end

    // random traffic against the model
    idle_in();
    for (int c = 0; c < 3000; c++) begin
      RST = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) iREN = ~iREN;
      if ($urandom_range(0, 4) == 0) dREN = ~dREN;
      if ($urandom_range(0, 5) == 0) dWEN = ~dWEN;
      case ($urandom_range(0, 9))
        0, 1:    rs = BUSY;
        2:       rs = FREE;
        3:       rs = ERROR;
        default: rs = ACCESS;
      endcase
      iaddr = $urandom; daddr = $urandom;
      ramload = $urandom;
      dstore = {$urandom, $urandom};
      settle();
      adv();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
